instr_fetch: RTL and testbench

//  Instruction-fetch sequencer sitting directly downstream of the 8-bit program counter.
//  On a fetch request it captures the PC value as the memory address and runs a req/ready

---
 rtl/instr_fetch.sv | 136 +++++++++++++
 tb/tb_instr_fetch.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction-fetch sequencer: captures PC into MAR, runs a req/ready read, loads MBR/IR, pulses inc_pc.
// Latency: start@N -> mem_req@N+1, ready@N+k -> pulses@N+k+1, idle@N+k+2; waits on mem_ready up to TIMEOUT cycles.
module instr_fetch #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int OPC_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              fetch_start,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mbr_out,
  output logic [OPC_W-1:0]  ir_out,
  output logic              inc_pc,
  output logic              fetch_done,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   mar;
  logic [DATA_W-1:0]   mbr;
  logic [OPC_W-1:0]    ir;
  logic [CNT_W-1:0]    wait_cnt;
  logic                err_q;

  logic                cap_addr;
  logic                latch_data;
  logic                cnt_clr;
  logic                cnt_inc;
  logic                err_set;
  logic                err_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // flush overrides everything, including a same-cycle mem_ready or fetch_start
  always_comb begin
    state_nxt  = state;
    cap_addr   = 1'b0;
    latch_data = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    if (flush) begin
      state_nxt = S_IDLE;
      cnt_clr   = 1'b1;
      err_clr   = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (fetch_start) begin
            state_nxt = S_WAIT;
            cap_addr  = 1'b1;
            cnt_clr   = 1'b1;
          end
        end
        S_WAIT: begin
          if (mem_ready) begin
            state_nxt  = S_DONE;
            latch_data = 1'b1;
          end else if (wait_cnt == CNT_LAST) begin
            state_nxt = S_ERR;
            err_set   = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        S_ERR:   state_nxt = S_ERR;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar      <= '0;
      mbr      <= '0;
      ir       <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (cap_addr) begin
        mar <= pc_in;
      end
      if (latch_data) begin
        mbr <= mem_rdata;
        ir  <= mem_rdata[DATA_W-1 -: OPC_W];
      end
      if (cnt_clr) begin
        wait_cnt <= '0;
      end else if (cnt_inc) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (err_clr) begin
        err_q <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  // Outputs are pure decodes of registered state, so no input reaches an output combinationally
  assign mem_req     = (state == S_WAIT);
  assign inc_pc      = (state == S_DONE);
  assign fetch_done  = (state == S_DONE);
  assign busy        = (state != S_IDLE);
  assign mem_addr    = mar;
  assign mbr_out     = mbr;
  assign ir_out      = ir;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: transaction-level expectations for each fetch outcome.
module tb_instr_fetch;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int OW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] pc_in;
  logic          fetch_start;
  logic          flush;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic [DW-1:0] mbr_out;
  logic [OW-1:0] ir_out;
  logic          inc_pc;
  logic          fetch_done;
  logic          busy;
  logic          timeout_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_mbr;

  instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .OPC_W(OW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .fetch_start(fetch_start), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mbr_out(mbr_out), .ir_out(ir_out), .inc_pc(inc_pc), .fetch_done(fetch_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_held();
    logic [DW-1:0] m;
    m = exp_mbr;
    check("mbr_held", mbr_out, m);
    check("ir_held", ir_out, m[DW-1 -: OW]);
  endtask

  // One fetch. wait_n = WAIT cycles without ready before ready (>= TO means never ready).
  // flush_at >= 0: assert flush together with mem_ready in that WAIT cycle instead.
  task automatic do_fetch(input logic [AW-1:0] pc, input int wait_n,
                          input logic [DW-1:0] data, input int flush_at);
    bit got, flushed;
    got = 0;
    flushed = 0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_req", mem_req, 0);
    pc_in = pc;
    fetch_start = 1'b1;
    flush = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      check("wait_req", mem_req, 1);
      check("wait_addr", mem_addr, pc);
      check("wait_busy", busy, 1);
      check("wait_inc", inc_pc, 0);
      check("wait_err", timeout_err, 0);
      // starts and PC changes while busy must be ignored
      fetch_start = 1'($urandom_range(0, 1));
      pc_in = 8'($urandom);
      mem_rdata = 16'($urandom);
      if (i == flush_at) begin
        flush = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 16'h1234;
        flushed = 1;
        break;
      end else if (i == wait_n) begin
        mem_ready = 1'b1;
        mem_rdata = data;
        got = 1;
        break;
      end else begin
        mem_ready = 1'b0;
      end
    end
    if (flushed) begin
      @(negedge clk);
      flush = 1'b0;
      mem_ready = 1'b0;
      fetch_start = 1'b0;
      check("flush_busy", busy, 0);
      check("flush_req", mem_req, 0);
      check("flush_inc", inc_pc, 0);
      check("flush_done", fetch_done, 0);
      check_held();
    end else if (got) begin
      exp_mbr = data;
      @(negedge clk);
      mem_ready = 1'b0;
      fetch_start = 1'($urandom_range(0, 1));
      check("done_inc", inc_pc, 1);
      check("done_fd", fetch_done, 1);
      check("done_req", mem_req, 0);
      check("done_busy", busy, 1);
      check("done_mbr", mbr_out, data);
      check("done_ir", ir_out, data[DW-1 -: OW]);
      @(negedge clk);
      fetch_start = 1'b0;
      check("post_busy", busy, 0);
      check("post_inc", inc_pc, 0);
      check("post_fd", fetch_done, 0);
    end else begin
      mem_ready = 1'b0;
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        fetch_start = 1'($urandom_range(0, 1));
        check("err_flag", timeout_err, 1);
        check("err_req", mem_req, 0);
        check("err_busy", busy, 1);
        check("err_inc", inc_pc, 0);
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      fetch_start = 1'b0;
      check("eflush_err", timeout_err, 0);
      check("eflush_busy", busy, 0);
      check_held();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n = 1'b0;
    pc_in = '0;
    fetch_start = 1'b0;
    flush = 1'b0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    exp_mbr = '0;
    #12;
    check("rst_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_mbr", mbr_out, 0);
    check("rst_err", timeout_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // zero-wait, wait states, last-cycle ready, timeout, flush race
    do_fetch(8'h05, 0, 16'h1A2B, -1);
    do_fetch(8'h05, 3, 16'hFFFF, -1);
    do_fetch(8'h3C, TO - 1, 16'hBEEF, -1);
    do_fetch(8'h44, TO, 16'h0000, -1);
    do_fetch(8'h77, 5, 16'h0000, 2);

    // flush together with start in IDLE: the start is dropped
    @(negedge clk);
    fetch_start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    flush = 1'b0;
    check("idle_flush_busy", busy, 0);
    check("idle_flush_req", mem_req, 0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: do_fetch(8'($urandom), TO, 16'($urandom), -1);
        1: do_fetch(8'($urandom), 6, 16'($urandom), int'($urandom_range(0, 5)));
        default: begin
          w = ($urandom_range(0, 3) == 0) ? TO - 1 : int'($urandom_range(0, 6));
          do_fetch(8'($urandom), w, 16'($urandom), -1);
        end
      endcase
    end

    // asynchronous reset in the middle of WAIT
    @(negedge clk);
    pc_in = 8'h5A;
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_mbr = '0;
    check("arst_req", mem_req, 0);
    check("arst_busy", busy, 0);
    check("arst_addr", mem_addr, 0);
    check("arst_mbr", mbr_out, 0);
    check("arst_ir", ir_out, 0);
    check("arst_inc", inc_pc, 0);
    check("arst_err", timeout_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_fetch(8'hA5, 1, 16'hC3D2, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
